// File: rtl/mprj_gpio_sequencer_pkg.sv
// Shared types and constants for the GPIO handshake sequencer.
package mprj_gpio_pkg;

    // Sequencer phases: boot delay, three handshake waits, then echo loop.
    typedef enum logic [2:0] {
        BOOT,
        W_F0,
        W_0F,
        W_00,
        LOOP
    } seq_state_t;

    // Handshake byte patterns.
    localparam logic [7:0] PAT_A0 = 8'hA0;
    localparam logic [7:0] PAT_F0 = 8'hF0;
    localparam logic [7:0] PAT_0B = 8'h0B;
    localparam logic [7:0] PAT_0F = 8'h0F;
    localparam logic [7:0] PAT_AB = 8'hAB;
    localparam logic [7:0] PAT_00 = 8'h00;

    // Pad bus geometry.
    localparam int unsigned PAD_W  = 38;
    localparam int unsigned HI_MSB = 31;
    localparam int unsigned HI_LSB = 24;
    localparam int unsigned LO_MSB = 23;
    localparam int unsigned LO_LSB = 16;
    localparam int unsigned BYTE_W = HI_MSB - HI_LSB + 1;

    // Echo loop reply: incoming byte plus one, wrapping at 8 bits.
    function automatic logic [7:0] echo_next(input logic [7:0] lo);
        return lo + 8'd1;
    endfunction

endpackage

// File: rtl/mprj_gpio_sequencer_in_sync.sv
// Multi-stage synchronizer for the sampled pad byte; clears to zero on reset.
module gpio_in_sync #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("gpio_in_sync: SYNC_STAGES must be at least 2");
    end

    logic [WIDTH-1:0] stage [SYNC_STAGES];

    // Shift the pad byte through the flop chain, oldest sample at the end.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[SYNC_STAGES-1];

endmodule

// File: rtl/mprj_gpio_sequencer.sv
// Pad-level GPIO handshake sequencer: boot delay, fixed pattern exchange,
// then an increment-echo loop on the user-project pad bus.
module mprj_gpio_sequencer
    import mprj_gpio_pkg::*;
#(
    parameter int unsigned BOOT_CYCLES = 64,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        resetb,
    inout  wire  [37:0] mprj_io
);

    localparam int unsigned CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

    seq_state_t         state;
    logic [CNT_W-1:0]   boot_cnt;
    logic [BYTE_W-1:0]  hi;
    logic               oe;
    logic [BYTE_W-1:0]  lo_s;

    gpio_in_sync #(
        .WIDTH       (BYTE_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_in_sync (
        .clock  (clock),
        .resetb (resetb),
        .din    (mprj_io[LO_MSB:LO_LSB]),
        .dout   (lo_s)
    );

    // Sequencer FSM: one transition per clock, all outputs registered.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state    <= BOOT;
            boot_cnt <= '0;
            hi       <= '0;
            oe       <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    if (boot_cnt == BOOT_LAST) begin
                        hi    <= PAT_A0;
                        oe    <= 1'b1;
                        state <= W_F0;
                    end else begin
                        boot_cnt <= boot_cnt + 1'b1;
                    end
                end
                W_F0: begin
                    if (lo_s == PAT_F0) begin
                        hi    <= PAT_0B;
                        state <= W_0F;
                    end
                end
                W_0F: begin
                    if (lo_s == PAT_0F) begin
                        hi    <= PAT_AB;
                        state <= W_00;
                    end
                end
                W_00: begin
                    if (lo_s == PAT_00) begin
                        state <= LOOP;
                    end
                end
                LOOP: begin
                    hi <= echo_next(lo_s);
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

    // Only the output byte is ever driven; every other pad stays released.
    assign mprj_io[HI_MSB:HI_LSB] = oe ? hi : {BYTE_W{1'bz}};
    assign mprj_io[37:32]         = 6'bzzzzzz;
    assign mprj_io[15:0]          = 16'hzzzz;

endmodule

// File: tb/tb_mprj_gpio_sequencer.sv
// Scoreboard bench for mprj_gpio_sequencer. Pads carry pullups, so a released
// pad reads as 1 and a fully released output byte reads 8'hFF.
module tb_mprj_gpio_sequencer;

    localparam int unsigned BOOT = 64;
    localparam int unsigned SYNC = 2;

    logic        clock  = 1'b0;
    logic        resetb = 1'b0;
    logic        lo_en  = 1'b0;
    logic [7:0]  lo_drv = 8'h00;
    wire  [37:0] mprj_io;

    assign mprj_io[23:16] = lo_en ? lo_drv : 8'hzz;

    for (genvar k = 0; k < 38; k++) begin : g_pu
        pullup (mprj_io[k]);
    end

    mprj_gpio_sequencer #(
        .BOOT_CYCLES (BOOT),
        .SYNC_STAGES (SYNC)
    ) u_dut (
        .clock   (clock),
        .resetb  (resetb),
        .mprj_io (mprj_io)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [7:0]  exp;
        int unsigned due;
        bit          probe;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  prev_hi = 8'hFF;

    // Monitor: other pads must stay released; output-byte changes and probes
    // are matched against the head of the expectation queue.
    always @(negedge clock) begin
        logic [7:0] cur;
        exp_t       e;
        cur = mprj_io[31:24];
        checks++;
        if ({mprj_io[37:32], mprj_io[15:0]} !== 22'h3FFFFF) begin
            errors++;
            $display("FAIL other_pads cyc=%0d got=%h want=3fffff", cyc,
                     {mprj_io[37:32], mprj_io[15:0]});
        end
        if (q.size() != 0 && q[0].probe) begin
            e = q.pop_front();
            checks++;
            if (cur !== e.exp) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%h want=%h", e.name, cyc, cur, e.exp);
            end
        end else if (cur !== prev_hi) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cyc=%0d got=%h was=%h", cyc, cur, prev_hi);
            end else begin
                e = q.pop_front();
                if (cur !== e.exp || cyc != e.due) begin
                    errors++;
                    $display("FAIL %s got=%h at cyc %0d want=%h at cyc %0d",
                             e.name, cur, cyc, e.exp, e.due);
                end
            end
        end
        prev_hi = cur;
    end

    // Reference model: position in the handshake list, then echo rule.
    int unsigned hs_idx = 0;
    logic [7:0]  hi_m   = 8'hFF;
    logic [7:0]  want_pat [3] = '{8'hF0, 8'h0F, 8'h00};
    logic [7:0]  reply_pat[2] = '{8'h0B, 8'hAB};

    function automatic void expect_change(input string name, input logic [7:0] v,
                                          input int unsigned due);
        if (v !== hi_m) begin
            q.push_back('{name, v, due, 1'b0});
            hi_m = v;
        end
    endfunction

    // A pad byte first seen by the bench at cycle t reaches the sequencer
    // decision SYNC+1 clocks later; entering the loop adds one more clock.
    function automatic void model_apply(input logic [7:0] v, input int unsigned t,
                                        input string name);
        logic [7:0] nxt;
        if (hs_idx < 3) begin
            if (v === want_pat[hs_idx]) begin
                if (hs_idx < 2) expect_change(name, reply_pat[hs_idx], t + SYNC + 1);
                hs_idx++;
                if (hs_idx == 3) begin
                    nxt = v + 8'd1;
                    expect_change(name, nxt, t + SYNC + 2);
                end
            end
        end else begin
            nxt = v + 8'd1;
            expect_change(name, nxt, t + SYNC + 1);
        end
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_lo(input logic [7:0] v, input string name);
        step();
        lo_en  = 1'b1;
        lo_drv = v;
        model_apply(v, cyc, name);
    endtask

    task automatic drain(input int unsigned limit, input string name);
        for (int unsigned i = 0; i < limit && q.size() != 0; i++) step();
        if (q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL %s timeout pending=%0d want=%h", name, q.size(), q[0].exp);
            q.delete();
        end
    endtask

    task automatic probe(input string name, input logic [7:0] v);
        drain(20, {name, "_pre"});
        q.push_back('{name, v, 0, 1'b1});
        drain(4, name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] v;

        // Reset and boot delay.
        resetb = 1'b0;
        lo_en  = 1'b1;
        lo_drv = 8'h5A;
        repeat (50) step();
        probe("reset_hi_z", 8'hFF);
        resetb = 1'b1;
        hs_idx = 0;
        hi_m   = 8'hFF;
        expect_change("boot_a0", 8'hA0, cyc + BOOT);
        drain(BOOT + 10, "boot_a0");

        // Out-of-order and junk values while waiting for F0.
        drive_lo(8'h0F, "wrong_0f");
        repeat (8) step();
        drive_lo(8'hAB, "wrong_ab");
        repeat (8) step();
        for (int i = 0; i < 5; i++) begin
            v = 8'($urandom);
            if (v == 8'hF0) v = 8'hF1;
            drive_lo(v, "wrong_rand");
            repeat ($urandom_range(3, 8)) step();
        end
        probe("wrong_hold_a0", 8'hA0);

        // Released input pads read through the pullups.
        step();
        lo_en = 1'b0;
        model_apply(8'hFF, cyc, "float");
        repeat (500) step();
        probe("float_hold_a0", 8'hA0);

        // Handshake.
        drive_lo(8'hF0, "hs_0b");
        drain(10, "hs_0b");
        drive_lo(8'h0F, "hs_ab");
        drain(10, "hs_ab");
        drive_lo(8'h00, "hs_loop_01");
        drain(10, "hs_loop_01");
        probe("loop_01", 8'h01);

        // Echo loop.
        drive_lo(8'h01, "echo_02");
        repeat (1000) step();
        probe("echo_02_hold", 8'h02);
        drive_lo(8'h03, "echo_04");
        drain(10, "echo_04");
        drive_lo(8'hFF, "echo_wrap");
        drain(10, "echo_wrap");
        probe("echo_wrap_00", 8'h00);
        for (int i = 0; i < 20; i++) begin
            drive_lo(8'($urandom), "echo_rand");
            repeat ($urandom_range(4, 10)) step();
            drain(10, "echo_rand");
        end

        // Reset pulse mid-loop: async release of the output byte, full reboot.
        drive_lo(8'h03, "pre_reset_04");
        drain(10, "pre_reset_04");
        probe("pre_reset_04_hold", 8'h04);
        step();
        expect_change("reset_async_z", 8'hFF, cyc);
        resetb = 1'b0;
        step();
        resetb = 1'b1;
        hs_idx = 0;
        expect_change("reboot_a0", 8'hA0, cyc + BOOT);
        drain(BOOT + 10, "reboot_a0");
        repeat (20) step();
        probe("reboot_hold_a0", 8'hA0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
